audio_dac_serializer: RTL and testbench

//  Playback end of the audio-out path: accepts stereo sample pairs on the write_audio_out handshake,

---
 rtl/audio_dac_serializer.sv | 185 ++++++++++++++++++
 tb/tb_audio_dac_serializer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_dac_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_dac_serializer
//  Description : Stereo sample FIFO feeding an I2S serializer for the WM8731
//                DAC. The codec is bit-clock master; BCLK and DACLRCK are
//                synchronized into the CLOCK_50 domain and edge-detected.
//  Revision    : 1.0  initial release
// ============================================================================
module audio_dac_serializer #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_BITS  = 32
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     clear_audio_out_memory,
   input  logic [31:0]              left_channel_audio_out,
   input  logic [31:0]              right_channel_audio_out,
   input  logic                     write_audio_out,
   input  logic                     AUD_BCLK,
   input  logic                     AUD_DACLRCK,
   output logic                     audio_out_allowed,
   output logic                     AUD_DACDAT,
   output logic [$clog2(DEPTH):0]   fifo_used,
   output logic                     underrun,
   output logic                     overflow
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int BC_W  = $clog2(SLOT_BITS + 1);
   localparam int PAIR_W = 2 * DATA_WIDTH;

   localparam logic [CNT_W-1:0] C_FULL     = CNT_W'(DEPTH);
   localparam logic [BC_W-1:0]  C_DATA_LEN = BC_W'(DATA_WIDTH);
   localparam logic [BC_W-1:0]  C_SLOT_LEN = BC_W'(SLOT_BITS);

   // Pin synchronizers: [0] meta, [1] synced, [2] history
   logic [2:0]            bclk_pipe_q, bclk_pipe_d;
   logic [2:0]            lrck_pipe_q, lrck_pipe_d;

   // FIFO state
   logic [PAIR_W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  allowed_q, allowed_d;
   logic                  overflow_q, overflow_d;
   logic                  underrun_q, underrun_d;

   // Serializer state
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] right_hold_q, right_hold_d;
   logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic                  armed_q, armed_d;
   logic                  dacdat_q, dacdat_d;

   logic                  w_bclk_fall;
   logic                  w_lrck_fall;
   logic                  w_lrck_rise;
   logic                  w_push;
   logic                  w_pop;
   logic [PAIR_W-1:0]     w_wr_pair;
   logic [PAIR_W-1:0]     w_rd_pair;

   assign w_bclk_fall = bclk_pipe_q[2] & ~bclk_pipe_q[1];
   assign w_lrck_fall = lrck_pipe_q[2] & ~lrck_pipe_q[1];
   assign w_lrck_rise = ~lrck_pipe_q[2] & lrck_pipe_q[1];

   // A full FIFO refuses writes based on last cycle's flag, even if a pop lands now.
   assign w_push    = write_audio_out & allowed_q & ~clear_audio_out_memory;
   assign w_pop     = w_lrck_fall & (count_q != '0) & ~clear_audio_out_memory;
   assign w_wr_pair = {left_channel_audio_out[31 -: DATA_WIDTH],
                       right_channel_audio_out[31 -: DATA_WIDTH]};
   assign w_rd_pair = mem_q[rd_ptr_q];

   // Low sample bits below DATA_WIDTH are never serialized.
   generate
      if (DATA_WIDTH < 32) begin : g_unused_low
         logic unused_low_bits;
         assign unused_low_bits = ^{left_channel_audio_out[31-DATA_WIDTH:0],
                                    right_channel_audio_out[31-DATA_WIDTH:0]};
      end
   endgenerate

   // Next-state: synchronizers, FIFO bookkeeping and I2S shifter.
   always_comb begin
      bclk_pipe_d  = {bclk_pipe_q[1:0], AUD_BCLK};
      lrck_pipe_d  = {lrck_pipe_q[1:0], AUD_DACLRCK};
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      shift_d      = shift_q;
      right_hold_d = right_hold_q;
      bit_cnt_d    = bit_cnt_q;
      armed_d      = armed_q;
      dacdat_d     = dacdat_q;

      overflow_d   = write_audio_out & ~allowed_q;
      // A frame start that delivers no data (empty or flushed) is an underrun.
      underrun_d   = w_lrck_fall & ~w_pop;

      if (clear_audio_out_memory) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      allowed_d = (count_d != C_FULL);

      // LRCK edges take priority over a coincident BCLK fall, which yields
      // the one-bit I2S delay. Every left frame start arms the shifter;
      // a right half before the first frame start sends zeros.
      if (w_lrck_fall) begin
         armed_d      = 1'b1;
         bit_cnt_d    = '0;
         shift_d      = w_pop ? w_rd_pair[PAIR_W-1 -: DATA_WIDTH] : '0;
         right_hold_d = w_pop ? w_rd_pair[DATA_WIDTH-1:0] : '0;
      end else if (w_lrck_rise) begin
         bit_cnt_d = '0;
         shift_d   = armed_q ? right_hold_q : '0;
      end else if (w_bclk_fall) begin
         if (bit_cnt_q < C_DATA_LEN) begin
            dacdat_d = shift_q[DATA_WIDTH-1];
            shift_d  = {shift_q[DATA_WIDTH-2:0], 1'b0};
         end else begin
            dacdat_d = 1'b0;
         end
         if (bit_cnt_q < C_SLOT_LEN) bit_cnt_d = bit_cnt_q + BC_W'(1);
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         bclk_pipe_q  <= '0;
         lrck_pipe_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         allowed_q    <= 1'b1;
         overflow_q   <= 1'b0;
         underrun_q   <= 1'b0;
         shift_q      <= '0;
         right_hold_q <= '0;
         bit_cnt_q    <= '0;
         armed_q      <= 1'b0;
         dacdat_q     <= 1'b0;
      end else begin
         bclk_pipe_q  <= bclk_pipe_d;
         lrck_pipe_q  <= lrck_pipe_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         allowed_q    <= allowed_d;
         overflow_q   <= overflow_d;
         underrun_q   <= underrun_d;
         shift_q      <= shift_d;
         right_hold_q <= right_hold_d;
         bit_cnt_q    <= bit_cnt_d;
         armed_q      <= armed_d;
         dacdat_q     <= dacdat_d;
      end
   end

   // Sample storage; contents are meaningless while the pointers say empty.
   always_ff @(posedge CLOCK_50) begin
      if (w_push) mem_q[wr_ptr_q] <= w_wr_pair;
   end

   assign audio_out_allowed = allowed_q;
   assign AUD_DACDAT        = dacdat_q;
   assign fifo_used         = count_q;
   assign underrun          = underrun_q;
   assign overflow          = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_dac_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_dac_serializer
//  Description : Self-checking bench for audio_dac_serializer. Drives an I2S
//                codec clock pattern and compares the serial stream against a
//                frame-level queue model of the playback FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_audio_dac_serializer;

   localparam int DEPTH = 16;
   localparam int DW    = 24;

   logic        clk = 1'b0;
   logic        reset;
   logic        clear_mem;
   logic [31:0] left_in;
   logic [31:0] right_in;
   logic        write_in;
   logic        bclk;
   logic        lrck;
   logic        allowed;
   logic        dacdat;
   logic [4:0]  used;
   logic        underrun;
   logic        overflow;

   audio_dac_serializer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .SLOT_BITS(32)) dut (
      .CLOCK_50                (clk),
      .reset                   (reset),
      .clear_audio_out_memory  (clear_mem),
      .left_channel_audio_out  (left_in),
      .right_channel_audio_out (right_in),
      .write_audio_out         (write_in),
      .AUD_BCLK                (bclk),
      .AUD_DACLRCK             (lrck),
      .audio_out_allowed       (allowed),
      .AUD_DACDAT              (dacdat),
      .fifo_used               (used),
      .underrun                (underrun),
      .overflow                (overflow)
   );

   always #10 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ur_seen = 0;

   // Reference model: FIFO of {left24,right24} pairs plus frame bookkeeping.
   logic [47:0] model_q [$];
   bit          model_armed = 1'b0;
   logic [23:0] model_right = '0;
   int          exp_ur = 0;

   always @(negedge clk) if (underrun === 1'b1) ur_seen++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Left frame start: returns the word for the left slot.
   function automatic logic [23:0] model_left_start();
      logic [47:0] p;
      model_armed = 1'b1;
      if (model_q.size() == 0) begin
         exp_ur++;
         model_right = '0;
         return '0;
      end
      p = model_q.pop_front();
      model_right = p[23:0];
      return p[47:24];
   endfunction

   task automatic push(input logic [31:0] l, input logic [31:0] r);
      bit acc;
      acc = (model_q.size() < DEPTH);
      left_in = l; right_in = r; write_in = 1'b1;
      tick(1);
      write_in = 1'b0;
      if (acc) model_q.push_back({l[31:8], r[31:8]});
      check("overflow", overflow, !acc);
      check("fifo_used_push", used, model_q.size());
      check("allowed", allowed, model_q.size() < DEPTH);
   endtask

   task automatic do_clear();
      clear_mem = 1'b1;
      tick(1);
      clear_mem = 1'b0;
      model_q.delete();
      check("fifo_used_clear", used, 0);
   endtask

   // One 32-BCLK half frame; BCLK period is 16 system clocks.
   task automatic do_slot(input bit lr, input bit push_start, input int clear_at, input int rst_at);
      logic [23:0] w;
      logic [31:0] pl, pr;
      int sz;
      sz = model_q.size();
      if (!lr) w = model_left_start();
      else     w = model_armed ? model_right : 24'h0;
      for (int k = 0; k < 32; k++) begin
         bclk = 1'b0;
         if (k == 0) lrck = lr;
         if (k == 0 && push_start) begin
            tick(2);
            pl = $urandom; pr = $urandom;
            left_in = pl; right_in = pr; write_in = 1'b1;
            tick(1);
            write_in = 1'b0;
            if (sz < DEPTH) model_q.push_back({pl[31:8], pr[31:8]});
            tick(5);
         end else if (k == clear_at) begin
            tick(5);
            do_clear();
            tick(2);
         end else begin
            tick(8);
         end
         bclk = 1'b1;
         tick(4);
         check(lr ? "dat_right" : "dat_left", dacdat,
               (k >= 1 && k <= DW) ? w[DW-k] : 1'b0);
         if (k == rst_at) begin
            reset = 1'b1;
            #1;
            check("rst_dacdat", dacdat, 0);
            check("rst_used", used, 0);
            model_q.delete();
            model_armed = 1'b0;
            model_right = '0;
            w = '0;
            tick(2);
            reset = 1'b0;
            tick(2);
         end else begin
            tick(4);
         end
      end
   endtask

   task automatic do_frame(input bit push_start, input int clear_at, input int rst_at);
      do_slot(1'b0, push_start, clear_at, rst_at);
      do_slot(1'b1, 1'b0, -1, -1);
      check("fifo_used_frame", used, model_q.size());
      check("underrun_count", ur_seen, exp_ur);
   endtask

   initial begin
      reset = 1'b1; clear_mem = 1'b0; write_in = 1'b0;
      left_in = '0; right_in = '0; bclk = 1'b1; lrck = 1'b0;
      tick(3);
      check("reset_used", used, 0);
      check("reset_allowed", allowed, 1);
      check("reset_dacdat", dacdat, 0);
      check("reset_underrun", underrun, 0);
      check("reset_overflow", overflow, 0);
      reset = 1'b0;
      tick(2);

      // Right half before any frame start carries zeros.
      do_slot(1'b1, 1'b0, -1, -1);

      // Directed extreme values.
      push(32'h8000_0000, 32'h7FFF_FF00);
      do_frame(1'b0, -1, -1);

      // Empty frames: silence plus one underrun each.
      repeat (3) do_frame(1'b0, -1, -1);

      // Fill to full, then one overflowing write, then drain.
      for (int i = 0; i < DEPTH; i++) push($urandom, $urandom);
      push(32'hDEAD_BEEF, 32'h1234_5678);
      repeat (DEPTH) do_frame(1'b0, -1, -1);

      // Push coinciding with a frame-start pop.
      push($urandom, $urandom);
      do_frame(1'b1, -1, -1);
      do_frame(1'b0, -1, -1);

      // Randomized traffic.
      for (int it = 0; it < 10; it++) begin
         int n;
         n = $urandom_range(0, 3);
         for (int j = 0; j < n; j++) push($urandom, $urandom);
         do_frame(1'($urandom_range(0, 1)), -1, -1);
      end

      // Flush mid-left-slot with five pairs still queued.
      do_clear();
      for (int i = 0; i < 6; i++) push($urandom, $urandom);
      do_frame(1'b0, 12, -1);
      do_frame(1'b0, -1, -1);

      // Reset during bit 10 of the left slot, then recover.
      push($urandom, $urandom);
      push($urandom, $urandom);
      do_frame(1'b0, -1, 10);
      push($urandom, $urandom);
      do_frame(1'b0, -1, -1);
      do_frame(1'b0, -1, -1);

      tick(4);
      check("underrun_final", ur_seen, exp_ur);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
